// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES core scheduler slice.
//   BLK_W     : plaintext/key/ciphertext width, fixed to the AES_top width
//   state_t   : scheduler FSM states
//   req_id_t  : requester identifier (0 = req0, 1 = req1)
package aes_ctrl_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/aes_core_sched_if.sv
// Bundle of every handshake/bus signal around the AES core scheduler.
//   req0_* / req1_* : requester valid/ready handshake with plaintext and key
//   rsp_*           : response valid/ready handshake with id, ciphertext, error
//   core_*          : connection to AES_top (enable, data/key in, data out, valid)
//   busy            : scheduler not idle
// Modports:
//   slave  : the scheduler itself
//   master : the environment (requesters, response consumer, AES core)
interface aes_core_sched_if;
  import aes_ctrl_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [BLK_W-1:0] req0_data;
  logic [BLK_W-1:0] req0_key;
  logic             req1_valid;
  logic             req1_ready;
  logic [BLK_W-1:0] req1_data;
  logic [BLK_W-1:0] req1_key;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [BLK_W-1:0] rsp_data;
  logic             rsp_err;

  logic             core_en;
  logic [BLK_W-1:0] core_data_in;
  logic [BLK_W-1:0] core_key_in;
  logic [BLK_W-1:0] core_data_out;
  logic             core_out_valid;

  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready,
    output core_en, core_data_in, core_key_in,
    input  core_data_out, core_out_valid,
    output busy
  );

  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready,
    input  core_en, core_data_in, core_key_in,
    output core_data_out, core_out_valid,
    input  busy
  );

endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req  : request vector {req1, req0}
//   last : requester granted most recently
//   gnt  : one-hot grant vector (all zero when nobody requests)
//   id   : index of the granted requester (0 when nobody requests)
module aes_rr_arb2
  import aes_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] gnt,
  output req_id_t    id
);

  always_comb begin
    gnt = 2'b00;
    id  = 1'b0;
    case (req)
      2'b01: begin
        gnt = 2'b01;
        id  = 1'b0;
      end
      2'b10: begin
        gnt = 2'b10;
        id  = 1'b1;
      end
      2'b11: begin
        // Contention: the requester that did not win last time goes first.
        id  = ~last;
        gnt = last ? 2'b01 : 2'b10;
      end
      default: begin
        gnt = 2'b00;
        id  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES_top encryption core between two requesters.
// Round-robin grant, registers the winning block+key onto the core inputs,
// holds core_en high until the core reports a result (or a timeout expires),
// presents the result on the response handshake, then idles the core for
// GAP_CYCLES before the next grant.
// Ports:
//   AES_clk    : clock, rising edge
//   AES_rst_n  : asynchronous active-low reset
//   bus        : aes_core_sched_if.slave (requesters, response, AES core, busy)
// Parameters:
//   TIMEOUT    : max cycles core_en stays high without core_out_valid
//   CNT_W      : timeout counter width, 2**CNT_W > TIMEOUT
//   GAP_CYCLES : cycles core_en is held low between operations (>= 1)
module aes_core_sched
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             AES_clk,
  input  logic             AES_rst_n,
  aes_core_sched_if.slave  bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [GAP_W-1:0] gap_cnt;
  req_id_t          last_grant;
  req_id_t          gnt_id;
  req_id_t          id_q;
  logic [1:0]       gnt;
  logic [BLK_W-1:0] data_q;
  logic [BLK_W-1:0] key_q;
  logic [BLK_W-1:0] rsp_data_q;
  logic             rsp_err_q;

  logic             accept;
  logic             timeout_hit;
  logic             gap_done;
  logic             req0_ready_c;
  logic             req1_ready_c;
  logic             core_en_c;
  logic             rsp_valid_c;
  logic             busy_c;

  aes_rr_arb2 u_arb (
    .req  ({bus.req1_valid, bus.req0_valid}),
    .last (last_grant),
    .gnt  (gnt),
    .id   (gnt_id)
  );

  // cnt counts completed ISSUE cycles; the TIMEOUT-th high cycle is the last.
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
  assign gap_done    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    core_en_c    = 1'b0;
    rsp_valid_c  = 1'b0;
    busy_c       = 1'b1;
    case (state)
      S_IDLE: begin
        busy_c       = 1'b0;
        req0_ready_c = gnt[0];
        req1_ready_c = gnt[1];
        // The arbiter only grants a requester that is valid.
        accept       = |gnt;
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        core_en_c = 1'b1;
        if (bus.core_out_valid || timeout_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accept edge: latch core inputs; ISSUE: capture result or timeout.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      data_q     <= '0;
      key_q      <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      gap_cnt    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        data_q     <= gnt_id ? bus.req1_data : bus.req0_data;
        key_q      <= gnt_id ? bus.req1_key  : bus.req0_key;
        id_q       <= gnt_id;
        last_grant <= gnt_id;
        cnt        <= '0;
      end
      if (state == S_ISSUE) begin
        cnt <= cnt_inc;
        // A result arriving in the timeout cycle still counts as success.
        if (bus.core_out_valid) begin
          rsp_data_q <= bus.core_data_out;
          rsp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if (state == S_RESP && bus.rsp_ready) begin
        gap_cnt <= '0;
      end
      if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  assign bus.req0_ready   = req0_ready_c;
  assign bus.req1_ready   = req1_ready_c;
  assign bus.core_en      = core_en_c;
  assign bus.core_data_in = data_q;
  assign bus.core_key_in  = key_q;
  assign bus.rsp_valid    = rsp_valid_c;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = busy_c;

endmodule

// File: tb/tb_aes_core_sched.sv
module tb_aes_core_sched;
  import aes_ctrl_pkg::*;

  logic AES_clk   = 1'b0;
  logic AES_rst_n = 1'b0;

  aes_core_sched_if bus ();

  aes_core_sched #(
    .TIMEOUT    (255),
    .CNT_W      (8),
    .GAP_CYCLES (1)
  ) dut (
    .AES_clk   (AES_clk),
    .AES_rst_n (AES_rst_n),
    .bus       (bus)
  );

  always #5 AES_clk = ~AES_clk;

  // Stand-in AES core: a keyed scramble that answers after `lat` enabled cycles.
  function automatic logic [127:0] aes_stub(input logic [127:0] d, input logic [127:0] k);
    return (d ^ {k[63:0], k[127:64]}) + 128'h1;
  endfunction

  int           lat         = 10;
  bit           never_valid = 1'b0;
  bit           pulse       = 1'b0;
  logic [127:0] pulse_data  = '0;
  int           hc          = 0;

  always @(posedge AES_clk) hc <= bus.core_en ? hc + 1 : 0;

  assign bus.core_out_valid = pulse | (bus.core_en && !never_valid && (hc == lat - 1));
  assign bus.core_data_out  = pulse ? pulse_data : aes_stub(bus.core_data_in, bus.core_key_in);

  int           checks   = 0;
  int           errors   = 0;
  int           ref_last = 1;
  int           exp_id   = 0;
  logic [127:0] exp_data = '0;
  logic [127:0] exp_rsp  = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset(input bit check_outputs);
    AES_rst_n      = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req0_key   = '0;
    bus.req1_data  = '0;
    bus.req1_key   = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(posedge AES_clk);
    #1;
    if (check_outputs) begin
      check("rst_core_en", bus.core_en, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_core_data_in", bus.core_data_in, '0);
      check("rst_rsp_data", bus.rsp_data, '0);
      check("rst_rsp_err_id", {bus.rsp_err, bus.rsp_id}, 2'b00);
    end
    AES_rst_n = 1'b1;
    ref_last  = 1;
    tick();
  endtask

  // Present requests in IDLE; the reference decides who must be granted.
  task automatic start_op(input bit v0, input bit v1,
                          input logic [127:0] d0, input logic [127:0] k0,
                          input logic [127:0] d1, input logic [127:0] k1);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_data  = d0;
    bus.req0_key   = k0;
    bus.req1_data  = d1;
    bus.req1_key   = k1;
    if (v0 && v1) exp_id = 1 - ref_last;
    else          exp_id = v1 ? 1 : 0;
    #1;
    check("ready_grant", {bus.req1_ready, bus.req0_ready}, (exp_id == 1) ? 2'b10 : 2'b01);
    exp_data = aes_stub(exp_id ? d1 : d0, exp_id ? k1 : k0);
    ref_last = exp_id;
    tick();
    // Later requester changes must not reach the core.
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = rnd128();
    bus.req0_key   = rnd128();
    bus.req1_data  = rnd128();
    bus.req1_key   = rnd128();
    #1;
    check("core_data_in", bus.core_data_in, exp_id ? d1 : d0);
    check("core_key_in", bus.core_key_in, exp_id ? k1 : k0);
  endtask

  task automatic finish_op(input int en_exp, input bit exp_err, input int hold, input bit gap_pulse);
    int n;
    n = 0;
    while (bus.core_en === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    exp_rsp = exp_err ? '0 : exp_data;
    check("core_en_cycles", n, en_exp);
    check("rsp_core_en_low", bus.core_en, 1'b0);
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_id", bus.rsp_id, exp_id[0]);
    check("rsp_err", bus.rsp_err, exp_err);
    check("rsp_data", bus.rsp_data, exp_rsp);
    for (int i = 0; i < hold; i++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      tick();
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_data", bus.rsp_data, exp_rsp);
      check("hold_id_err", {bus.rsp_id, bus.rsp_err}, {exp_id[0], exp_err});
      check("hold_ready", {bus.req1_ready, bus.req0_ready, bus.core_en}, 3'b000);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    tick();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    pulse          = gap_pulse;
    pulse_data     = rnd128();
    #1;
    check("gap_state", {bus.busy, bus.rsp_valid, bus.core_en, bus.req0_ready}, 4'b1000);
    tick();
    pulse          = 1'b0;
    bus.req0_valid = 1'b0;
    #1;
    check("back_idle", {bus.busy, bus.rsp_valid, bus.core_en}, 3'b000);
    check("rsp_data_kept", bus.rsp_data, exp_rsp);
  endtask

  initial begin
    bus.rsp_ready = 1'b0;
    do_reset(1'b1);

    // Directed op from req0, 50-cycle core.
    lat = 50;
    start_op(1'b1, 1'b0, {32'h000000e8, 96'h0}, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
             rnd128(), rnd128());
    finish_op(50, 1'b0, 0, 1'b0);

    // Contention from reset: alternating grants 0,1,0,1.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      lat = $urandom_range(20, 3);
      start_op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128());
      finish_op(lat, 1'b0, 0, 1'b0);
    end

    // Random single/dual requests.
    for (int i = 0; i < 4; i++) begin
      bit v0, v1;
      v0  = 1'(($urandom_range(2, 0) != 1));
      v1  = ~v0 | 1'($urandom_range(1, 0));
      lat = $urandom_range(12, 1);
      start_op(v0, v1, rnd128(), rnd128(), rnd128(), rnd128());
      finish_op(lat, 1'b0, 0, 1'b0);
    end

    // Core never answers: timeout after 255 enabled cycles.
    never_valid = 1'b1;
    start_op(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), rnd128());
    finish_op(255, 1'b1, 0, 1'b0);
    never_valid = 1'b0;

    // Response backpressure for 10 cycles.
    lat = 7;
    start_op(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), rnd128());
    finish_op(7, 1'b0, 10, 1'b0);

    // Stray core_out_valid in IDLE is ignored.
    pulse      = 1'b1;
    pulse_data = rnd128();
    tick();
    pulse      = 1'b0;
    check("idle_pulse_state", {bus.busy, bus.rsp_valid, bus.core_en}, 3'b000);
    check("idle_pulse_data", bus.rsp_data, exp_rsp);

    // Stray core_out_valid in GAP is ignored.
    lat = 4;
    start_op(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), rnd128());
    finish_op(4, 1'b0, 0, 1'b1);

    // Result arrives in the timeout cycle: success wins.
    lat = 255;
    start_op(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), rnd128());
    finish_op(255, 1'b0, 0, 1'b0);

    // Reset in cycle 20 of ISSUE: outputs drop without a clock edge.
    lat = 60;
    start_op(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), rnd128());
    repeat (19) tick();
    check("pre_rst_core_en", bus.core_en, 1'b1);
    #2;
    AES_rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {bus.core_en, bus.rsp_valid, bus.busy}, 3'b000);
    @(posedge AES_clk);
    #1;
    AES_rst_n = 1'b1;
    ref_last  = 1;
    tick();
    check("post_rst_idle", {bus.busy, bus.rsp_valid}, 2'b00);
    lat = 5;
    start_op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128());
    finish_op(5, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
